// File: rtl/rf_writeback_if.sv
// Port bundle for rf_writeback: ALU/load result inputs, register-file write port,
// decode-stage forwarding lookups and queue occupancy.
interface rf_writeback_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;

    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    logic          write_enable;
    logic [AW-1:0] write_address3;
    logic [DW-1:0] write_data3;

    logic [AW-1:0] read_address1;
    logic [AW-1:0] read_address2;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data2;

    logic [CW-1:0] pending_count;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output load_valid, load_addr, load_data,
        output read_address1, read_address2,
        input  load_ready,
        input  write_enable, write_address3, write_data3,
        input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
        input  pending_count
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  load_valid, load_addr, load_data,
        input  read_address1, read_address2,
        output load_ready,
        output write_enable, write_address3, write_data3,
        output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
        output pending_count
    );
endinterface

// File: rtl/rf_writeback.sv
// Register-file write arbiter: ALU results win, loads wait in a DEPTH-entry queue; one cycle to write_enable.
// Loads are backpressured only by a full queue (load_ready from registered occupancy); ALU has no backpressure.
module rf_writeback #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_writeback_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Load queue; a slot is occupied by position (head..head+cnt), valid bit marks squash
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Output stage feeding the register file
    logic             we_q, we_d;
    logic [AW-1:0]    wa_q, wa_d;
    logic [DW-1:0]    wd_q, wd_d;

    logic alu_take, full, empty, load_acc, load_keep, pop, cut, push;

    always_comb begin
        alu_take  = wb.alu_valid && (wb.alu_addr != '0);
        full      = (cnt_q == CW'(DEPTH));
        empty     = (cnt_q == '0);
        load_acc  = wb.load_valid && !full;
        // A same-cycle ALU write to the same register is younger, so the load is dead
        load_keep = load_acc && (wb.load_addr != '0)
                    && !(wb.alu_valid && (wb.alu_addr == wb.load_addr));
        pop       = !empty && !alu_take;
        cut       = empty && !alu_take && load_keep;
        push      = load_keep && !cut;
    end

    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (alu_take) begin
            we_d = 1'b1;
            wa_d = wb.alu_addr;
            wd_d = wb.alu_data;
        end else if (pop) begin
            if (ent_vld_q[head_q]) begin
                we_d = 1'b1;
                wa_d = addr_q[head_q];
                wd_d = data_q[head_q];
            end
        end else if (cut) begin
            we_d = 1'b1;
            wa_d = wb.load_addr;
            wd_d = wb.load_data;
        end
    end

    always_comb begin
        ent_vld_d = ent_vld_q;
        addr_d    = addr_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;

        // WAW: an issuing ALU write kills every older queued write to the same register
        if (alu_take) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == wb.alu_addr) begin
                    ent_vld_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            ent_vld_d[head_q] = 1'b0;
            head_d            = head_q + 1'b1;
        end

        if (push) begin
            ent_vld_d[tail_q] = 1'b1;
            addr_d[tail_q]    = wb.load_addr;
            data_d[tail_q]    = wb.load_data;
            tail_d            = tail_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
        end
    end

    // Forwarding: output stage first, then walk queue oldest->youngest so the youngest wins
    logic [AW-1:0] ra     [2];
    logic          fhit   [2];
    logic [DW-1:0] fdat   [2];

    always_comb begin
        ra[0] = wb.read_address1;
        ra[1] = wb.read_address2;
    end

    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            fhit[p] = 1'b0;
            fdat[p] = '0;
            if (we_q && (wa_q == ra[p])) begin
                fhit[p] = 1'b1;
                fdat[p] = wd_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + i[PW-1:0];
                if ((CW'(i) < cnt_q) && ent_vld_q[idx] && (addr_q[idx] == ra[p])) begin
                    fhit[p] = 1'b1;
                    fdat[p] = data_q[idx];
                end
            end
            if (ra[p] == '0) begin
                fhit[p] = 1'b0;
                fdat[p] = '0;
            end
        end
    end

    assign wb.load_ready     = !full;
    assign wb.pending_count  = cnt_q;
    assign wb.write_enable   = we_q;
    assign wb.write_address3 = wa_q;
    assign wb.write_data3    = wd_q;
    assign wb.fwd_hit1       = fhit[0];
    assign wb.fwd_data1      = fdat[0];
    assign wb.fwd_hit2       = fhit[1];
    assign wb.fwd_data2      = fdat[1];
endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, ALU issue, cut-through, queue fill/drain,
// squash, same-cycle conflict, forwarding and asynchronous mid-run reset.
module tb_rf_writeback;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rf_writeback_if #(.DEPTH(4), .DW(32), .AW(5)) wb ();

    rf_writeback #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb.alu_valid = v;
        wb.alu_addr  = a;
        wb.alu_data  = d;
    endtask

    task automatic set_load(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb.load_valid = v;
        wb.load_addr  = a;
        wb.load_data  = d;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"}, 32'(wb.write_enable), 32'd1);
        check({tag, "_wa"}, 32'(wb.write_address3), 32'(a));
        check({tag, "_wd"}, wb.write_data3, d);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_alu(1'b0, 5'd0, 32'd0);
        set_load(1'b0, 5'd0, 32'd0);
        wb.read_address1 = 5'd5;
        wb.read_address2 = 5'd0;

        // Reset state
        #12;
        check("rst_we", 32'(wb.write_enable), 32'd0);
        check("rst_wa", 32'(wb.write_address3), 32'd0);
        check("rst_wd", wb.write_data3, 32'd0);
        check("rst_cnt", 32'(wb.pending_count), 32'd0);
        check("rst_rdy", 32'(wb.load_ready), 32'd1);
        check("rst_hit1", 32'(wb.fwd_hit1), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU only
        set_alu(1'b1, 5'd7, 32'hDEADBEEF);
        tick();
        check_wr("alu7", 5'd7, 32'hDEADBEEF);
        set_alu(1'b1, 5'd0, 32'h55);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        check("alu0_we", 32'(wb.write_enable), 32'd0);
        check("alu0_wa_hold", 32'(wb.write_address3), 32'd7);

        // Cut-through load
        set_load(1'b1, 5'd3, 32'h11);
        #1;
        check("cut_rdy", 32'(wb.load_ready), 32'd1);
        tick();
        set_load(1'b0, 5'd0, 32'd0);
        check_wr("cut", 5'd3, 32'h11);
        check("cut_cnt", 32'(wb.pending_count), 32'd0);

        // Fill: ALU for 6 cycles, loads r8..r11 then r12 offered while full
        for (int k = 0; k < 6; k++) begin
            set_alu(1'b1, 5'(k + 1), 32'h100 + 32'(k));
            if (k < 4) set_load(1'b1, 5'(8 + k), 32'h80 + 32'(k));
            else       set_load(1'b1, 5'd12, 32'hC);
            #1;
            check("fill_rdy", 32'(wb.load_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
            check("fill_wa", 32'(wb.write_address3), 32'(k + 1));
            check("fill_wd", wb.write_data3, 32'h100 + 32'(k));
        end
        check("fill_cnt", 32'(wb.pending_count), 32'd4);

        // Drain: first pop raises load_ready on the next cycle
        set_alu(1'b0, 5'd0, 32'd0);
        set_load(1'b0, 5'd0, 32'd0);
        #1;
        check("drain_rdy0", 32'(wb.load_ready), 32'd0);
        tick();
        check_wr("drain8", 5'd8, 32'h80);
        check("drain_rdy1", 32'(wb.load_ready), 32'd1);
        check("drain_cnt3", 32'(wb.pending_count), 32'd3);
        set_load(1'b1, 5'd13, 32'hD13);
        tick();
        set_load(1'b0, 5'd0, 32'd0);
        check_wr("drain9", 5'd9, 32'h81);
        check("pushpop_cnt", 32'(wb.pending_count), 32'd3);
        tick();
        check_wr("drain10", 5'd10, 32'h82);
        check("drain_cnt2", 32'(wb.pending_count), 32'd2);
        tick();
        check_wr("drain11", 5'd11, 32'h83);
        tick();
        check_wr("drain13", 5'd13, 32'hD13);
        check("drain_cnt0", 32'(wb.pending_count), 32'd0);
        tick();
        check("drain_idle_we", 32'(wb.write_enable), 32'd0);

        // Squash
        set_alu(1'b1, 5'd1, 32'h1);
        set_load(1'b1, 5'd5, 32'hAAAA);
        tick();
        set_load(1'b0, 5'd0, 32'd0);
        wb.read_address1 = 5'd5;
        #1;
        check("sq_cnt1", 32'(wb.pending_count), 32'd1);
        check("sq_fwd_hit_q", 32'(wb.fwd_hit1), 32'd1);
        check("sq_fwd_dat_q", wb.fwd_data1, 32'hAAAA);
        set_alu(1'b1, 5'd5, 32'hBBBB);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        check_wr("sq_alu5", 5'd5, 32'hBBBB);
        check("sq_cnt_held", 32'(wb.pending_count), 32'd1);
        check("sq_fwd_dat_o", wb.fwd_data1, 32'hBBBB);
        tick();
        check("sq_pop_we", 32'(wb.write_enable), 32'd0);
        check("sq_cnt0", 32'(wb.pending_count), 32'd0);
        check("sq_fwd_gone", 32'(wb.fwd_hit1), 32'd0);
        tick();
        check("sq_after_we", 32'(wb.write_enable), 32'd0);

        // Same-cycle load/ALU conflict
        set_alu(1'b1, 5'd9, 32'h2);
        set_load(1'b1, 5'd9, 32'h1);
        #1;
        check("cf_rdy", 32'(wb.load_ready), 32'd1);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        set_load(1'b0, 5'd0, 32'd0);
        check_wr("cf", 5'd9, 32'h2);
        check("cf_cnt", 32'(wb.pending_count), 32'd0);
        tick();
        check("cf_after_we", 32'(wb.write_enable), 32'd0);

        // Forwarding: youngest queued entry wins, output stage hits, r0 never hits
        set_alu(1'b1, 5'd1, 32'h1);
        set_load(1'b1, 5'd4, 32'h10);
        tick();
        set_alu(1'b1, 5'd2, 32'h2222);
        set_load(1'b1, 5'd4, 32'h20);
        tick();
        set_alu(1'b1, 5'd3, 32'h3);
        set_load(1'b1, 5'd6, 32'h30);
        wb.read_address1 = 5'd4;
        wb.read_address2 = 5'd2;
        #1;
        check("fw_hit1", 32'(wb.fwd_hit1), 32'd1);
        check("fw_dat1", wb.fwd_data1, 32'h20);
        check("fw_hit2_out", 32'(wb.fwd_hit2), 32'd1);
        check("fw_dat2_out", wb.fwd_data2, 32'h2222);
        check("fw_cnt2", 32'(wb.pending_count), 32'd2);
        wb.read_address2 = 5'd0;
        #1;
        check("fw_hit2_r0", 32'(wb.fwd_hit2), 32'd0);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        set_load(1'b0, 5'd0, 32'd0);
        check("fw_cnt3", 32'(wb.pending_count), 32'd3);

        // Asynchronous reset with 3 entries queued, checked before any clock edge
        rst_n = 1'b0;
        #2;
        check("arst_we", 32'(wb.write_enable), 32'd0);
        check("arst_wa", 32'(wb.write_address3), 32'd0);
        check("arst_wd", wb.write_data3, 32'd0);
        check("arst_cnt", 32'(wb.pending_count), 32'd0);
        check("arst_rdy", 32'(wb.load_ready), 32'd1);
        check("arst_hit1", 32'(wb.fwd_hit1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
